// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator (pixel/line counters, sync, blanking).
// Optional one-cycle start-of-vblank strobe when VGA_TIMING_FRAME_TICK_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out
`ifdef VGA_TIMING_FRAME_TICK_EN
  ,
  output logic        frame_tick
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end
  endgenerate

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        hblnk_next;
  logic        vblnk_next;

  // Flags are decoded from the next counter values so they register alongside the counters.
  always_comb begin
    h_next = hcount_out + 11'd1;
    v_next = vcount_out;
    if (hcount_out == H_LAST) begin
      h_next = '0;
      v_next = (vcount_out == V_LAST) ? '0 : vcount_out + 11'd1;
    end
    hblnk_next = (h_next >= H_BLNK_START);
    hsync_next = (h_next >= H_SYNC_START) && (h_next <= H_SYNC_END);
    vblnk_next = (v_next >= V_BLNK_START);
    vsync_next = (v_next >= V_SYNC_START) && (v_next <= V_SYNC_END);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      hcount_out <= h_next;
      vcount_out <= v_next;
      hsync_out  <= hsync_next;
      vsync_out  <= vsync_next;
      hblnk_out  <= hblnk_next;
      vblnk_out  <= vblnk_next;
    end
  end

`ifdef VGA_TIMING_FRAME_TICK_EN
  logic frame_tick_next;

  assign frame_tick_next = (h_next == '0) && (v_next == V_BLNK_START);

  always_ff @(posedge pclk) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_tick_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: a small raster plus a 640x480 instance,
// both checked every cycle against an arithmetic position model.
module tb_vga_timing_gen;

  // Small raster keeps full frames short.
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [10:0] g_hcount, g_vcount;
  logic        g_hsync, g_vsync, g_hblnk, g_vblnk;
`ifdef VGA_TIMING_FRAME_TICK_EN
  logic        frame_tick;
  logic        g_frame_tick;
`endif

  int tests  = 0;
  int failed = 0;
  int t      = 0;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int hb;
    int vb;
    int ft;
  } exp_t;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut (
    .pclk      (pclk),
    .rst       (rst),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out)
`ifdef VGA_TIMING_FRAME_TICK_EN
    ,
    .frame_tick(frame_tick)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33)
  ) u_vga (
    .pclk      (pclk),
    .rst       (rst),
    .hcount_out(g_hcount),
    .vcount_out(g_vcount),
    .hsync_out (g_hsync),
    .vsync_out (g_vsync),
    .hblnk_out (g_hblnk),
    .vblnk_out (g_vblnk)
`ifdef VGA_TIMING_FRAME_TICK_EN
    ,
    .frame_tick(g_frame_tick)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // t = number of clock edges with rst high since the last reset edge.
  function automatic exp_t model(int tt, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb);
    exp_t m;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    m.h  = tt % ht;
    m.v  = (tt / ht) % vt;
    m.hb = (m.h >= ha) ? 1 : 0;
    m.hs = (m.h >= ha + hf && m.h < ha + hf + hs) ? 1 : 0;
    m.vb = (m.v >= va) ? 1 : 0;
    m.vs = (m.v >= va + vf && m.v < va + vf + vs) ? 1 : 0;
    m.ft = (tt > 0 && m.h == 0 && m.v == va) ? 1 : 0;
    return m;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp_v);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    exp_t g;
    rst = r;
    @(posedge pclk);
    #1;
    if (!r) t = 0;
    else    t = t + 1;
    e = model(t, HA, HF, HS, HB, VA, VF, VS, VB);
    g = model(t, 640, 16, 96, 48, 480, 10, 2, 33);
    check("hcount", int'(hcount_out), e.h);
    check("vcount", int'(vcount_out), e.v);
    check("hsync",  int'(hsync_out),  e.hs);
    check("vsync",  int'(vsync_out),  e.vs);
    check("hblnk",  int'(hblnk_out),  e.hb);
    check("vblnk",  int'(vblnk_out),  e.vb);
    check("vga_hcount", int'(g_hcount), g.h);
    check("vga_vcount", int'(g_vcount), g.v);
    check("vga_hsync",  int'(g_hsync),  g.hs);
    check("vga_hblnk",  int'(g_hblnk),  g.hb);
    check("vga_vsync",  int'(g_vsync),  g.vs);
    check("vga_vblnk",  int'(g_vblnk),  g.vb);
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("frame_tick", int'(frame_tick), e.ft);
`endif
  endtask

  initial begin
    int n;
    int ticks;
    int last_tick;
    int hs_len;
    rst = 1'b0;

    // Reset held for 5 cycles; all outputs at zero.
    repeat (5) step(1'b0);
    check("hcount_release_cycle", int'(hcount_out), 0);

    // Three full frames; count frame ticks and hsync width on the way.
    ticks = 0;
    last_tick = -1;
    hs_len = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      step(1'b1);
      if (t <= HT && hsync_out === 1'b1) hs_len++;
`ifdef VGA_TIMING_FRAME_TICK_EN
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) check("tick_spacing", t - last_tick, FT);
        last_tick = t;
        ticks++;
      end
`endif
    end
    check("hsync_width", hs_len, HS);
    check("frame_return_h", int'(hcount_out), 0);
    check("frame_return_v", int'(vcount_out), 0);
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("tick_count", ticks, 3);
`endif

    // Mid-frame resets at random positions, then resume from (0,0).
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(40, 900));
      repeat (n) step(1'b1);
      step(1'b0);
      check("reset_h", int'(hcount_out), 0);
      check("reset_v", int'(vcount_out), 0);
      step(1'b1);
    end

    // Continue past the 640x480 line wrap (800) to exercise its vcount increment.
    repeat (900) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
